conv_frame_sched: RTL and testbench
===================================

# conv_frame_sched

Frame-level scheduler for the 3x3 convolution front end. It loads one 480x272 RGB888 frame from a host pixel stream into the single-port frame BRAM. It then hands the BRAM port to the 3x3 window generator, enables it, and counts the windows it emits. It forwards MAC back-pressure, waits for the MAC to drain, and signals frame completion. It sits between the host/DMA interface, the frame BRAM, the window generator and the MAC.

## Interface
- DATA_W, 24, pixel width (RGB888)
- ADDR_W, 17, BRAM address width
- DEPTH, 130560, pixels per frame (480*272)
- NUM_WIN, 130560, windows expected per frame
- iClk  in  1  clock
- iRst  in  1  reset, asynchronous, active-low
- iStart  in  1  start pulse; honoured only in IDLE
- iSkipLoad  in  1  sampled with iStart; 1 skips LOAD and reuses the resident frame
- iAbort  in  1  synchronous abort; 1-cycle pulse
- iLoadValid / oLoadReady  in/out  1  host pixel handshake
- iLoadData  in  DATA_W  host pixel
- oWinEn  out  1  window generator enable
- oWinBusy  out  1  window generator stall
- iWinCs  in  1  window generator BRAM chip select
- iWinAddr  in  ADDR_W  window generator BRAM address
- iWinValid  in  1  window emitted
- iMacBusy  in  1  MAC stall request
- oBramCs, oBramWe  out  1  BRAM port control
- oBramAddr  out  ADDR_W  BRAM address
- oBramWdata  out  DATA_W  BRAM write data
- oDone  out  1  1-cycle frame-complete pulse
- oState  out  3  current state, for debug

## Operation
- States: IDLE=0, LOAD=1, RUN=2, DRAIN=3, DONE=4.
- IDLE:
  - iStart & !iSkipLoad -> LOAD.
  - iStart & iSkipLoad -> RUN.
  - All counters are cleared on leaving IDLE.
- LOAD:
  - oLoadReady=1.
  - Each cycle with iLoadValid=1 writes the pixel: oBramCs=oBramWe=1, oBramAddr=rLoadCnt, oBramWdata=iLoadData, then rLoadCnt++.
  - A write with rLoadCnt==DEPTH-1 -> RUN.
- RUN:
  - oWinEn=1.
  - BRAM port is muxed to the window generator: oBramCs=iWinCs, oBramAddr=iWinAddr, oBramWe=0.
  - oWinBusy=iMacBusy.
  - Each iWinValid increments rWinCnt.
  - A valid with rWinCnt==NUM_WIN-1 -> DRAIN.
- DRAIN:
  - oWinEn=0, BRAM idle.
  - Stay while iMacBusy=1; the first cycle with iMacBusy=0 -> DONE.
- DONE:
  - oDone=1 for exactly one cycle -> IDLE.
- iAbort in any non-IDLE state -> IDLE next cycle. No oDone. Counters cleared. oWinEn drops on that edge.
- Port ownership is exclusive: outside LOAD the host never reaches the BRAM; outside RUN the window generator never reaches it. In all other states oBramCs=oBramWe=0.
- Counters are ADDR_W bits and never wrap: the terminal compares force the state exit first.

## Timing
- Reset values: state=IDLE, both counters=0. Every output reads 0 except oState=0.
- Registered: state, counters, oDone.
- Combinational from state: oLoadReady, oWinEn, oWinBusy, and the BRAM port mux.
- iStart -> first LOAD cycle or first RUN cycle: 1 clock.
- Last load write -> oWinEn=1: 1 clock.
- Last iWinValid -> DRAIN: 1 clock. DRAIN with iMacBusy=0 -> DONE next edge.
- Minimum end-of-frame latency from the last valid to oDone: 2 clocks.
- iStart while not IDLE is ignored.
- iAbort and iStart in the same IDLE cycle: start wins.
- iAbort in the same cycle as a terminal event: abort wins.
- iLoadValid outside LOAD is ignored, with no write.
- iWinValid outside RUN is not counted.
- Asynchronous reset mid-frame returns to IDLE immediately and drops oWinEn and oBramCs without a clock.

## Structure
- The shared package holds:
  - state encodings IDLE..DONE;
  - frame constants WIDTH=480, HEIGHT=272, DEPTH;
  - DATA_W/ADDR_W defaults.
- No sub-module. State register, two counters and the port mux are implemented in one module.

## Test plan
- Reset then iStart with iSkipLoad=0; stream 130560 pixels with iLoadValid held 1 -> addresses 0..130559 written once each; oWinEn rises 1 clock after the last write.
- LOAD with iLoadValid toggled every other cycle -> exactly DEPTH writes, no address skipped or repeated, oLoadReady stays 1.
- RUN with a window-generator model, NUM_WIN overridden to 16, iMacBusy held 1 for 5 cycles after the last valid -> oWinBusy mirrors iMacBusy; DRAIN lasts 5 cycles; single oDone pulse.
- iStart with iSkipLoad=1 -> direct IDLE->RUN; oBramWe never asserted.
- iAbort at rLoadCnt=1000, then a fresh start -> IDLE next cycle, no oDone, restart writes begin at address 0.
- Async reset deasserted/asserted mid-RUN -> oWinEn=0 and oBramCs=0 immediately; iStart ignored in RUN; counters read 0 after reset.

Source files
------------

// File: rtl/conv_frame_sched_pkg.sv
// conv_frame_sched_pkg: shared state encodings and frame constants
// for the 3x3 convolution front-end scheduler.
package conv_frame_sched_pkg;

    localparam int WIDTH      = 480;
    localparam int HEIGHT     = 272;
    localparam int DEPTH      = WIDTH * HEIGHT;
    localparam int DEF_DATA_W = 24;
    localparam int DEF_ADDR_W = 17;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/conv_frame_sched.sv
// conv_frame_sched: loads a frame into the single-port BRAM, hands the
// port to the window generator, counts windows, drains the MAC.
module conv_frame_sched
    import conv_frame_sched_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DEPTH   = conv_frame_sched_pkg::DEPTH,
    parameter int NUM_WIN = conv_frame_sched_pkg::DEPTH
) (
    input  logic              iClk,
    input  logic              iRst,
    input  logic              iStart,
    input  logic              iSkipLoad,
    input  logic              iAbort,
    input  logic              iLoadValid,
    output logic              oLoadReady,
    input  logic [DATA_W-1:0] iLoadData,
    output logic              oWinEn,
    output logic              oWinBusy,
    input  logic              iWinCs,
    input  logic [ADDR_W-1:0] iWinAddr,
    input  logic              iWinValid,
    input  logic              iMacBusy,
    output logic              oBramCs,
    output logic              oBramWe,
    output logic [ADDR_W-1:0] oBramAddr,
    output logic [DATA_W-1:0] oBramWdata,
    output logic              oDone,
    output logic [2:0]        oState
);

    state_e            rState;
    state_e            wNext;
    logic [ADDR_W-1:0] rLoadCnt;
    logic [ADDR_W-1:0] rWinCnt;
    logic              rDone;
    logic              wLoadLast;
    logic              wWinLast;

    assign wLoadLast = iLoadValid && (rLoadCnt == ADDR_W'(DEPTH - 1));
    assign wWinLast  = iWinValid && (rWinCnt == ADDR_W'(NUM_WIN - 1));

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            rState <= S_IDLE;
        end else begin
            rState <= wNext;
        end
    end

    // Abort overrides every terminal event outside IDLE.
    always_comb begin
        wNext = rState;
        unique case (rState)
            S_IDLE:  if (iStart) wNext = iSkipLoad ? S_RUN : S_LOAD;
            S_LOAD:  if (wLoadLast) wNext = S_RUN;
            S_RUN:   if (wWinLast) wNext = S_DRAIN;
            S_DRAIN: if (!iMacBusy) wNext = S_DONE;
            S_DONE:  wNext = S_IDLE;
            default: wNext = S_IDLE;
        endcase
        if (iAbort && rState != S_IDLE) begin
            wNext = S_IDLE;
        end
    end

    // Terminal compares leave the state before a counter could wrap.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            rLoadCnt <= '0;
            rWinCnt  <= '0;
            rDone    <= 1'b0;
        end else begin
            rDone <= (wNext == S_DONE);
            if (wNext == S_IDLE) begin
                rLoadCnt <= '0;
                rWinCnt  <= '0;
            end else begin
                if (rState == S_LOAD && iLoadValid && !wLoadLast) begin
                    rLoadCnt <= rLoadCnt + ADDR_W'(1);
                end
                if (rState == S_RUN && iWinValid && !wWinLast) begin
                    rWinCnt <= rWinCnt + ADDR_W'(1);
                end
            end
        end
    end

    always_comb begin
        oLoadReady = 1'b0;
        oWinEn     = 1'b0;
        oWinBusy   = 1'b0;
        oBramCs    = 1'b0;
        oBramWe    = 1'b0;
        oBramAddr  = '0;
        oBramWdata = '0;
        unique case (rState)
            S_LOAD: begin
                oLoadReady = 1'b1;
                oBramCs    = iLoadValid;
                oBramWe    = iLoadValid;
                oBramAddr  = rLoadCnt;
                oBramWdata = iLoadData;
            end
            S_RUN: begin
                oWinEn    = 1'b1;
                oWinBusy  = iMacBusy;
                oBramCs   = iWinCs;
                oBramAddr = iWinAddr;
            end
            default: begin
            end
        endcase
    end

    assign oDone  = rDone;
    assign oState = rState;

endmodule

// File: tb/tb_conv_frame_sched.sv
// tb_conv_frame_sched: directed checks of the frame scheduler with a
// reduced frame (DEPTH=64, NUM_WIN=16) to keep runs short.
module tb_conv_frame_sched;

    localparam int DW  = 24;
    localparam int AW  = 17;
    localparam int DEP = 64;
    localparam int NW  = 16;

    logic          iClk;
    logic          iRst;
    logic          iStart;
    logic          iSkipLoad;
    logic          iAbort;
    logic          iLoadValid;
    logic          oLoadReady;
    logic [DW-1:0] iLoadData;
    logic          oWinEn;
    logic          oWinBusy;
    logic          iWinCs;
    logic [AW-1:0] iWinAddr;
    logic          iWinValid;
    logic          iMacBusy;
    logic          oBramCs;
    logic          oBramWe;
    logic [AW-1:0] oBramAddr;
    logic [DW-1:0] oBramWdata;
    logic          oDone;
    logic [2:0]    oState;

    int nChecks = 0;
    int nFails  = 0;

    conv_frame_sched #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .DEPTH  (DEP),
        .NUM_WIN(NW)
    ) dut (
        .iClk      (iClk),
        .iRst      (iRst),
        .iStart    (iStart),
        .iSkipLoad (iSkipLoad),
        .iAbort    (iAbort),
        .iLoadValid(iLoadValid),
        .oLoadReady(oLoadReady),
        .iLoadData (iLoadData),
        .oWinEn    (oWinEn),
        .oWinBusy  (oWinBusy),
        .iWinCs    (iWinCs),
        .iWinAddr  (iWinAddr),
        .iWinValid (iWinValid),
        .iMacBusy  (iMacBusy),
        .oBramCs   (oBramCs),
        .oBramWe   (oBramWe),
        .oBramAddr (oBramAddr),
        .oBramWdata(oBramWdata),
        .oDone     (oDone),
        .oState    (oState)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    task automatic tick();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iStart     = 1'b0;
        iSkipLoad  = 1'b0;
        iAbort     = 1'b0;
        iLoadValid = 1'b0;
        iLoadData  = '0;
        iWinCs     = 1'b0;
        iWinAddr   = '0;
        iWinValid  = 1'b0;
        iMacBusy   = 1'b0;
    endtask

    task automatic test_reset();
        iRst       = 1'b0;
        iLoadValid = 1'b1;
        iLoadData  = 24'hABCDEF;
        iWinCs     = 1'b1;
        iWinAddr   = 17'd5;
        iMacBusy   = 1'b1;
        #3;
        nChecks++;
        if ({oLoadReady, oWinEn, oWinBusy, oBramCs, oBramWe, oDone,
             oState, oBramAddr, oBramWdata} !== '0) begin
            nFails++;
            $display("FAIL reset_outputs: state=%0d cs=%b we=%b en=%b exp all 0",
                     oState, oBramCs, oBramWe, oWinEn);
        end
        tick();
        iRst = 1'b1;
        tick();
        tick();
        nChecks++;
        if (oState !== 3'd0 || oBramWe !== 1'b0 || oBramCs !== 1'b0) begin
            nFails++;
            $display("FAIL idle_ignores_inputs: state=%0d we=%b cs=%b exp 0 0 0",
                     oState, oBramWe, oBramCs);
        end
        idle_inputs();
    endtask

    task automatic test_load_full();
        iSkipLoad = 1'b0;
        iStart    = 1'b1;
        tick();
        iStart = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd1 || oLoadReady !== 1'b1) begin
            nFails++;
            $display("FAIL load_entry: state=%0d ready=%b exp 1 1", oState, oLoadReady);
        end
        for (int k = 0; k < DEP; k++) begin
            iLoadValid = 1'b1;
            iLoadData  = DW'(24'h100 + k * 3);
            #1;
            nChecks++;
            if (oBramCs !== 1'b1 || oBramWe !== 1'b1 || oBramAddr !== AW'(k) ||
                oBramWdata !== DW'(24'h100 + k * 3)) begin
                nFails++;
                $display("FAIL load_write: addr=%0d data=%h we=%b exp addr=%0d data=%h we=1",
                         oBramAddr, oBramWdata, oBramWe, k, DW'(24'h100 + k * 3));
            end
            tick();
        end
        iLoadValid = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd2 || oWinEn !== 1'b1 || oLoadReady !== 1'b0) begin
            nFails++;
            $display("FAIL load_to_run: state=%0d en=%b ready=%b exp 2 1 0",
                     oState, oWinEn, oLoadReady);
        end
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd0 || oWinEn !== 1'b0 || oDone !== 1'b0) begin
            nFails++;
            $display("FAIL abort_run: state=%0d en=%b done=%b exp 0 0 0",
                     oState, oWinEn, oDone);
        end
    endtask

    task automatic test_load_toggle();
        int nWr  = 0;
        int nBad = 0;
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int c = 0; c < 2 * DEP - 1; c++) begin
            iLoadValid = (c % 2 == 0);
            iLoadData  = DW'(c);
            #1;
            if (oLoadReady !== 1'b1) nBad++;
            if (iLoadValid) begin
                if (oBramWe !== 1'b1 || oBramAddr !== AW'(nWr)) nBad++;
                if (oBramWe === 1'b1) nWr++;
            end else if (oBramWe !== 1'b0 || oBramCs !== 1'b0) begin
                nBad++;
            end
            tick();
        end
        iLoadValid = 1'b0;
        #1;
        nChecks++;
        if (nBad != 0 || nWr != DEP) begin
            nFails++;
            $display("FAIL load_toggle_writes: writes=%0d bad_cycles=%0d exp %0d 0",
                     nWr, nBad, DEP);
        end
        nChecks++;
        if (oState !== 3'd2) begin
            nFails++;
            $display("FAIL load_toggle_exit: state=%0d exp 2", oState);
        end
        iAbort = 1'b1;
        tick();
        iAbort = 1'b0;
    endtask

    task automatic test_run_drain();
        int nBad = 0;
        iLoadValid = 1'b1;
        iSkipLoad  = 1'b1;
        iStart     = 1'b1;
        tick();
        iStart    = 1'b0;
        iSkipLoad = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd2 || oWinEn !== 1'b1) begin
            nFails++;
            $display("FAIL skip_to_run: state=%0d en=%b exp 2 1", oState, oWinEn);
        end
        for (int k = 0; k < NW; k++) begin
            iWinValid = 1'b1;
            iWinCs    = 1'b1;
            iWinAddr  = AW'(k * 7);
            iMacBusy  = (k % 3 == 1);
            #1;
            if (oBramCs !== 1'b1 || oBramWe !== 1'b0 || oBramAddr !== AW'(k * 7) ||
                oWinBusy !== (k % 3 == 1) || oState !== 3'd2) nBad++;
            tick();
        end
        nChecks++;
        if (nBad != 0) begin
            nFails++;
            $display("FAIL run_port_mux: bad_cycles=%0d exp 0", nBad);
        end
        iWinValid = 1'b0;
        iMacBusy  = 1'b1;
        #1;
        nChecks++;
        if (oState !== 3'd3 || oWinEn !== 1'b0 || oBramCs !== 1'b0 ||
            oWinBusy !== 1'b0 || oBramWe !== 1'b0) begin
            nFails++;
            $display("FAIL drain_entry: state=%0d en=%b cs=%b busy=%b exp 3 0 0 0",
                     oState, oWinEn, oBramCs, oWinBusy);
        end
        nBad = 0;
        for (int c = 0; c < 5; c++) begin
            iMacBusy = 1'b1;
            #1;
            if (oState !== 3'd3 || oDone !== 1'b0) nBad++;
            tick();
        end
        iMacBusy = 1'b0;
        #1;
        if (oState !== 3'd3 || oDone !== 1'b0) nBad++;
        nChecks++;
        if (nBad != 0) begin
            nFails++;
            $display("FAIL drain_hold: bad_cycles=%0d exp 0", nBad);
        end
        tick();
        nChecks++;
        if (oState !== 3'd4 || oDone !== 1'b1) begin
            nFails++;
            $display("FAIL done_pulse: state=%0d done=%b exp 4 1", oState, oDone);
        end
        tick();
        nChecks++;
        if (oState !== 3'd0 || oDone !== 1'b0) begin
            nFails++;
            $display("FAIL done_single: state=%0d done=%b exp 0 0", oState, oDone);
        end
        idle_inputs();
    endtask

    task automatic test_abort_terminal();
        iSkipLoad = 1'b1;
        iStart    = 1'b1;
        tick();
        iStart = 1'b0;
        for (int k = 0; k < NW; k++) begin
            iWinValid = 1'b1;
            iAbort    = (k == NW - 1);
            tick();
        end
        iWinValid = 1'b0;
        iAbort    = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd0 || oDone !== 1'b0) begin
            nFails++;
            $display("FAIL abort_wins_terminal: state=%0d done=%b exp 0 0", oState, oDone);
        end
        iStart = 1'b1;
        iAbort = 1'b1;
        tick();
        iStart = 1'b0;
        iAbort = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd2) begin
            nFails++;
            $display("FAIL start_beats_abort: state=%0d exp 2", oState);
        end
        for (int k = 0; k < NW - 1; k++) begin
            iWinValid = 1'b1;
            tick();
        end
        iWinValid = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd2) begin
            nFails++;
            $display("FAIL win_cnt_cleared: state=%0d exp 2", oState);
        end
        iWinValid = 1'b1;
        tick();
        iWinValid = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd3 || oDone !== 1'b0) begin
            nFails++;
            $display("FAIL min_latency_drain: state=%0d done=%b exp 3 0", oState, oDone);
        end
        tick();
        nChecks++;
        if (oDone !== 1'b1) begin
            nFails++;
            $display("FAIL min_latency_done: done=%b exp 1", oDone);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_abort_load();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
        for (int k = 0; k < 20; k++) begin
            iLoadValid = 1'b1;
            tick();
        end
        iAbort = 1'b1;
        tick();
        iAbort     = 1'b0;
        iLoadValid = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd0 || oLoadReady !== 1'b0 || oDone !== 1'b0) begin
            nFails++;
            $display("FAIL abort_load: state=%0d ready=%b done=%b exp 0 0 0",
                     oState, oLoadReady, oDone);
        end
        tick();
        nChecks++;
        if (oDone !== 1'b0) begin
            nFails++;
            $display("FAIL abort_no_done: done=%b exp 0", oDone);
        end
        iStart = 1'b1;
        tick();
        iStart     = 1'b0;
        iLoadValid = 1'b1;
        #1;
        nChecks++;
        if (oBramWe !== 1'b1 || oBramAddr !== AW'(0)) begin
            nFails++;
            $display("FAIL restart_addr0: we=%b addr=%0d exp 1 0", oBramWe, oBramAddr);
        end
        tick();
        #1;
        nChecks++;
        if (oBramAddr !== AW'(1)) begin
            nFails++;
            $display("FAIL restart_addr1: addr=%0d exp 1", oBramAddr);
        end
        iLoadValid = 1'b0;
        iAbort     = 1'b1;
        tick();
        idle_inputs();
    endtask

    task automatic test_async_reset();
        iSkipLoad = 1'b1;
        iStart    = 1'b1;
        tick();
        iStart    = 1'b0;
        iSkipLoad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            iWinValid = 1'b1;
            tick();
        end
        iWinValid = 1'b0;
        iStart    = 1'b1;
        tick();
        iStart = 1'b0;
        iWinCs = 1'b1;
        #1;
        nChecks++;
        if (oState !== 3'd2 || oBramCs !== 1'b1) begin
            nFails++;
            $display("FAIL start_ignored_run: state=%0d cs=%b exp 2 1", oState, oBramCs);
        end
        #1;
        iRst = 1'b0;
        #1;
        nChecks++;
        if (oWinEn !== 1'b0 || oBramCs !== 1'b0 || oState !== 3'd0) begin
            nFails++;
            $display("FAIL async_reset: en=%b cs=%b state=%0d exp 0 0 0",
                     oWinEn, oBramCs, oState);
        end
        tick();
        iRst = 1'b1;
        idle_inputs();
        tick();
        iSkipLoad = 1'b1;
        iStart    = 1'b1;
        tick();
        iStart    = 1'b0;
        iSkipLoad = 1'b0;
        for (int k = 0; k < NW - 1; k++) begin
            iWinValid = 1'b1;
            tick();
        end
        iWinValid = 1'b0;
        #1;
        nChecks++;
        if (oState !== 3'd2) begin
            nFails++;
            $display("FAIL reset_win_cnt: state=%0d exp 2", oState);
        end
        iWinValid = 1'b1;
        tick();
        iWinValid = 1'b0;
        tick();
        tick();
        iStart = 1'b1;
        tick();
        iStart     = 1'b0;
        iLoadValid = 1'b1;
        #1;
        nChecks++;
        if (oState !== 3'd1 || oBramAddr !== AW'(0) || oBramWe !== 1'b1) begin
            nFails++;
            $display("FAIL reset_load_cnt: state=%0d addr=%0d we=%b exp 1 0 1",
                     oState, oBramAddr, oBramWe);
        end
        iLoadValid = 1'b0;
        iAbort     = 1'b1;
        tick();
        idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        idle_inputs();
        iRst = 1'b0;
        test_reset();
        test_load_full();
        test_load_toggle();
        test_run_drain();
        test_abort_terminal();
        test_abort_load();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
